// File: rtl/slow_clk_monitor.sv
// Slow divided-clock monitor: synchronises Clk2_in, emits edge strobes, measures
// each half-period and tracks lock / loss of the slow clock.
module slow_clk_monitor #(
  parameter int unsigned HALF_PERIOD = 25000001,
  parameter int unsigned TOL         = 16,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clk2_in,
  output logic             Tick,
  output logic             Tick_fall,
  output logic             Locked,
  output logic             Lost,
  output logic             Period_err,
  output logic [CNT_W-1:0] Half_cnt
);

  localparam logic [1:0] ACQUIRE = 2'd0;
  localparam logic [1:0] LOCKED  = 2'd1;
  localparam logic [1:0] LOST    = 2'd2;

  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(HALF_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(HALF_PERIOD + TOL);

  logic             sync1, sync2, prev;
  logic             rise, fall, any_edge;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             in_tol, timeout;
  logic [1:0]       state, state_nx;
  logic [1:0]       good_cnt, good_nx;
  logic             first_edge_seen, seen_nx;
  logic             perr_nx;

  assign rise     = sync2 & ~prev;
  assign fall     = ~sync2 & prev;
  assign any_edge = rise | fall;

  // cnt+1 saturates so a long-dead slow clock keeps reading as timed out
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign in_tol  = (cnt_inc >= LO_LIM) && (cnt_inc <= HI_LIM);
  assign timeout = ~any_edge && (cnt_inc > HI_LIM);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    seen_nx  = first_edge_seen;
    perr_nx  = 1'b0;
    case (state)
      ACQUIRE: begin
        if (any_edge) begin
          if (!first_edge_seen) begin
            seen_nx = 1'b1;
          end else if (in_tol) begin
            if (good_cnt == 2'd1) begin
              state_nx = LOCKED;
              good_nx  = 2'd0;
            end else begin
              good_nx = good_cnt + 2'd1;
            end
          end else begin
            perr_nx = 1'b1;
            good_nx = 2'd0;
          end
        end else if (timeout) begin
          state_nx = LOST;
          good_nx  = 2'd0;
        end
      end
      LOCKED: begin
        if (any_edge) begin
          if (!in_tol) begin
            perr_nx  = 1'b1;
            state_nx = ACQUIRE;
            good_nx  = 2'd0;
            seen_nx  = 1'b1;
          end
        end else if (timeout) begin
          state_nx = LOST;
        end
      end
      LOST: begin
        // the reviving edge opens a fresh measurement, it is not checked
        if (any_edge) begin
          state_nx = ACQUIRE;
          good_nx  = 2'd0;
          seen_nx  = 1'b1;
        end
      end
      default: state_nx = ACQUIRE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      prev            <= 1'b0;
      cnt             <= '0;
      good_cnt        <= 2'd0;
      state           <= ACQUIRE;
      first_edge_seen <= 1'b0;
      Tick            <= 1'b0;
      Tick_fall       <= 1'b0;
      Locked          <= 1'b0;
      Lost            <= 1'b0;
      Period_err      <= 1'b0;
      Half_cnt        <= '0;
    end else begin
      sync1           <= Clk2_in;
      sync2           <= sync1;
      prev            <= sync2;
      cnt             <= any_edge ? '0 : cnt_inc;
      good_cnt        <= good_nx;
      state           <= state_nx;
      first_edge_seen <= seen_nx;
      Tick            <= rise;
      Tick_fall       <= fall;
      Locked          <= (state_nx == LOCKED);
      Lost            <= (state_nx == LOST);
      Period_err      <= perr_nx;
      if (any_edge && first_edge_seen) Half_cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with a short slow clock (10-cycle halves,
// tolerance 1, 8-bit counter).
module tb_slow_clk_monitor;

  localparam int CNT_W = 8;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Clk2_in;
  logic             Tick, Tick_fall, Locked, Lost, Period_err;
  logic [CNT_W-1:0] Half_cnt;

  int checks = 0;
  int errors = 0;
  int perr_cnt = 0;
  int tick_cnt = 0;

  slow_clk_monitor #(.HALF_PERIOD(10), .TOL(1), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Clk2_in    (Clk2_in),
    .Tick       (Tick),
    .Tick_fall  (Tick_fall),
    .Locked     (Locked),
    .Lost       (Lost),
    .Period_err (Period_err),
    .Half_cnt   (Half_cnt)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #2;
    if (Period_err) perr_cnt++;
    if (Tick) tick_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Change the slow clock on a negedge; its strobes are visible 3 negedges later.
  task automatic edge_go(input logic lvl);
    Clk2_in = lvl;
    step(3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"}, Tick, 0);
    chk({tag, "_tfall"}, Tick_fall, 0);
    chk({tag, "_locked"}, Locked, 0);
    chk({tag, "_lost"}, Lost, 0);
    chk({tag, "_perr"}, Period_err, 0);
    chk({tag, "_half"}, Half_cnt, 0);
  endtask

  initial begin
    Clk2_in = 1'b0;
    Rst_n   = 1'b1;
    #1 Rst_n = 1'b0;
    #3 chk_zero("rst");
    step(2);
    Rst_n = 1'b1;

    // clean square wave to lock
    edge_go(1'b1);
    chk("a_tick1", Tick, 1); chk("a_half_first", Half_cnt, 0); chk("a_lock1", Locked, 0);
    step(1); chk("a_tick_width", Tick, 0); step(6);
    edge_go(1'b0);
    chk("a_tfall", Tick_fall, 1); chk("a_half2", Half_cnt, 10); chk("a_lock2", Locked, 0);
    step(7);
    edge_go(1'b1);
    chk("a_lock3", Locked, 1); chk("a_tick3", Tick, 1); step(7);
    edge_go(1'b0); step(7);
    edge_go(1'b1);
    chk("a_no_perr", perr_cnt, 0); chk("a_tick_count", tick_cnt, 3); step(7);

    // tolerance edges while locked
    edge_go(1'b0); step(8);
    edge_go(1'b1);
    chk("b_half11", Half_cnt, 11); chk("b_lock11", Locked, 1); chk("b_perr11", Period_err, 0);
    step(6);
    edge_go(1'b0);
    chk("b_half9", Half_cnt, 9); chk("b_lock9", Locked, 1); step(9);
    edge_go(1'b1);
    chk("b_perr12", Period_err, 1); chk("b_half12", Half_cnt, 12);
    chk("b_unlock", Locked, 0); chk("b_lost12", Lost, 0); chk("b_tick12", Tick, 1);
    step(1); chk("b_perr_width", Period_err, 0); step(6);
    edge_go(1'b0);
    chk("b_relock_a", Locked, 0); chk("b_half10", Half_cnt, 10); step(7);
    edge_go(1'b1);
    chk("b_relock", Locked, 1); step(7);

    // slow clock stops
    step(4);
    chk("c_lost_early", Lost, 0); chk("c_lock_early", Locked, 1);
    step(1);
    chk("c_lost", Lost, 1); chk("c_lock_drop", Locked, 0);
    step(300);
    chk("c_lost_hold", Lost, 1);
    edge_go(1'b0);
    chk("c_lost_clear", Lost, 0); chk("c_tfall_lost", Tick_fall, 1); chk("c_lock_r0", Locked, 0);
    step(7);
    edge_go(1'b1);
    chk("c_lock_r1", Locked, 0); chk("c_half_r1", Half_cnt, 10); step(7);
    edge_go(1'b0);
    chk("c_lock_r2", Locked, 1); step(2);

    // 3-cycle glitch inside a low phase
    edge_go(1'b1);
    chk("d_tick", Tick, 1); chk("d_perr_rise", Period_err, 1);
    chk("d_half5", Half_cnt, 5); chk("d_unlock", Locked, 0);
    edge_go(1'b0);
    chk("d_tfall", Tick_fall, 1); chk("d_half3", Half_cnt, 3); chk("d_perr_fall", Period_err, 1);
    step(7);
    edge_go(1'b1);
    chk("d_lock_a", Locked, 0); step(7);
    edge_go(1'b0);
    chk("d_relock", Locked, 1); step(3);

    // asynchronous reset mid-half
    #2 Rst_n = 1'b0;
    #1 chk_zero("e_rst");
    @(negedge Clk);
    Rst_n = 1'b1;
    edge_go(1'b1);
    chk("e_tick", Tick, 1); chk("e_half_first", Half_cnt, 0);
    chk("e_perr_first", Period_err, 0); chk("e_lock0", Locked, 0);
    step(7);
    edge_go(1'b0);
    chk("e_half2", Half_cnt, 10); chk("e_lock1", Locked, 0); step(7);
    edge_go(1'b1);
    chk("e_lock", Locked, 1); step(9);

    // edge coincident with timeout
    edge_go(1'b0);
    chk("f_perr", Period_err, 1); chk("f_half12", Half_cnt, 12);
    chk("f_lock", Locked, 0); chk("f_lost", Lost, 0);
    step(1); chk("f_lost_next", Lost, 0);
    step(11); chk("f_acq_timeout", Lost, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
